// File: rtl/mem_port2_arbiter.sv
// Two-requester round-robin arbiter with burst lock for the 64-bit second memory port.
// Commands are registered toward memory, and each read return is steered back to the requester that issued it.
module mem_port2_arbiter #(
  parameter int DEPTH_WORDS = 8960,
  parameter int MAX_HOLD    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_write,
  input  logic        m0_lock,
  input  logic [13:0] m0_address,
  input  logic [7:0]  m0_byteenable,
  input  logic [63:0] m0_writedata,
  output logic [63:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_write,
  input  logic        m1_lock,
  input  logic [13:0] m1_address,
  input  logic [7:0]  m1_byteenable,
  input  logic [63:0] m1_writedata,
  output logic [63:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [13:0] mem_address,
  output logic [7:0]  mem_byteenable,
  output logic [63:0] mem_writedata,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic        mem_clken,
  input  logic [63:0] mem_readdata,
  output logic        addr_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [14:0] LP_DEPTH     = 15'(DEPTH_WORDS);
  localparam logic [7:0]  LP_HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0]  LP_HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      r_state;
  logic        r_rr;
  logic [7:0]  r_hold;
  logic [13:0] r_mem_addr;
  logic [7:0]  r_mem_be;
  logic [63:0] r_mem_wd;
  logic        r_mem_cs;
  logic        r_mem_we;
  logic        r_mem_clken;
  logic        r_addr_err;
  logic        r_tag0_v, r_tag0_id, r_tag0_oob;
  logic        r_tag1_v, r_tag1_id, r_tag1_oob;
  logic        r_m0_rdv, r_m1_rdv;
  logic [63:0] r_m0_rdata, r_m1_rdata;

  logic        w_g1, w_gnt, w_acc, w_oob, w_switch, w_release;
  logic        w_sel_valid, w_sel_lock, w_sel_write, w_other_valid;
  logic [13:0] w_sel_addr;
  logic [7:0]  w_sel_be;
  logic [63:0] w_sel_wd;

  // Mux the granted requester; ready is decoded from registered state only.
  assign w_g1          = (r_state == GNT1);
  assign w_gnt         = (r_state == GNT0) | (r_state == GNT1);
  assign w_sel_valid   = w_g1 ? m1_valid      : m0_valid;
  assign w_sel_lock    = w_g1 ? m1_lock       : m0_lock;
  assign w_sel_write   = w_g1 ? m1_write      : m0_write;
  assign w_sel_addr    = w_g1 ? m1_address    : m0_address;
  assign w_sel_be      = w_g1 ? m1_byteenable : m0_byteenable;
  assign w_sel_wd      = w_g1 ? m1_writedata  : m0_writedata;
  assign w_other_valid = w_g1 ? m0_valid      : m1_valid;
  assign w_acc         = w_gnt & w_sel_valid;
  assign w_oob         = ({1'b0, w_sel_addr} >= LP_DEPTH);
  assign w_switch      = w_other_valid & (~w_sel_lock | (w_acc & (r_hold == LP_HOLD_LAST)));
  assign w_release     = ~w_sel_valid & ~w_sel_lock;

  // Grant FSM with round-robin pointer and lock hold counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_hold  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_valid && m1_valid) r_state <= r_rr ? GNT1 : GNT0;
          else if (m0_valid)        r_state <= GNT0;
          else if (m1_valid)        r_state <= GNT1;
          else                      r_state <= IDLE;
        end
        GNT0, GNT1: begin
          if (w_switch) begin
            r_state <= w_g1 ? GNT0 : GNT1;
            r_hold  <= 8'd0;
            r_rr    <= w_g1;
          end else begin
            if (w_acc && (r_hold != LP_HOLD_MAX)) r_hold <= r_hold + 8'd1;
            if (w_release) begin
              r_state <= IDLE;
              r_rr    <= ~w_g1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory command register, sticky range error, and the two-stage return tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr  <= 14'd0;
      r_mem_be    <= 8'd0;
      r_mem_wd    <= 64'd0;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_clken <= 1'b0;
      r_addr_err  <= 1'b0;
      r_tag0_v    <= 1'b0;
      r_tag0_id   <= 1'b0;
      r_tag0_oob  <= 1'b0;
      r_tag1_v    <= 1'b0;
      r_tag1_id   <= 1'b0;
      r_tag1_oob  <= 1'b0;
    end else begin
      r_mem_clken <= 1'b1;
      r_mem_cs    <= w_acc & ~w_oob;
      r_mem_we    <= w_acc & ~w_oob & w_sel_write;
      if (w_acc) begin
        r_mem_addr <= w_sel_addr;
        r_mem_be   <= w_sel_be;
        r_mem_wd   <= w_sel_wd;
      end
      // A new error wins over a simultaneous clear.
      if (w_acc && w_oob) r_addr_err <= 1'b1;
      else if (err_clr)   r_addr_err <= 1'b0;
      r_tag0_v   <= w_acc & ~w_sel_write;
      r_tag0_id  <= w_g1;
      r_tag0_oob <= w_oob;
      r_tag1_v   <= r_tag0_v;
      r_tag1_id  <= r_tag0_id;
      r_tag1_oob <= r_tag0_oob;
    end
  end

  // Read return capture; out-of-range reads return zero at normal latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m0_rdv   <= 1'b0;
      r_m1_rdv   <= 1'b0;
      r_m0_rdata <= 64'd0;
      r_m1_rdata <= 64'd0;
    end else begin
      r_m0_rdv <= r_tag1_v & ~r_tag1_id;
      r_m1_rdv <= r_tag1_v & r_tag1_id;
      if (r_tag1_v && !r_tag1_id) r_m0_rdata <= r_tag1_oob ? 64'd0 : mem_readdata;
      if (r_tag1_v && r_tag1_id)  r_m1_rdata <= r_tag1_oob ? 64'd0 : mem_readdata;
    end
  end

  assign m0_ready         = (r_state == GNT0);
  assign m1_ready         = (r_state == GNT1);
  assign m0_readdata      = r_m0_rdata;
  assign m1_readdata      = r_m1_rdata;
  assign m0_readdatavalid = r_m0_rdv;
  assign m1_readdatavalid = r_m1_rdv;
  assign mem_address      = r_mem_addr;
  assign mem_byteenable   = r_mem_be;
  assign mem_writedata    = r_mem_wd;
  assign mem_chipselect   = r_mem_cs;
  assign mem_write        = r_mem_we;
  assign mem_clken        = r_mem_clken;
  assign addr_err         = r_addr_err;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Directed bench for mem_port2_arbiter: an arbitration vector table plus hand sequences
// for read steering, lock hold, out-of-range handling and mid-operation reset.
module tb_mem_port2_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_valid, m0_ready, m0_write, m0_lock, m0_readdatavalid;
  logic [13:0] m0_address;
  logic [7:0]  m0_byteenable;
  logic [63:0] m0_writedata, m0_readdata;
  logic        m1_valid, m1_ready, m1_write, m1_lock, m1_readdatavalid;
  logic [13:0] m1_address;
  logic [7:0]  m1_byteenable;
  logic [63:0] m1_writedata, m1_readdata;
  logic [13:0] mem_address;
  logic [7:0]  mem_byteenable;
  logic [63:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [63:0] mem_readdata;
  logic        addr_err, err_clr;

  int n_checks = 0;
  int n_errors = 0;
  int m0_rdv_cnt = 0;
  int m1_rdv_cnt = 0;
  int cs_cnt = 0;

  localparam logic [63:0] DATA_A = 64'hDEADBEEF_01234567;

  logic [63:0] tb_mem [0:8959];

  always #5 clk = ~clk;

  mem_port2_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write), .m0_lock(m0_lock),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write), .m1_lock(m1_lock),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .addr_err(addr_err), .err_clr(err_clr)
  );

  // Memory model: samples the registered command, read data valid the following cycle.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 8; b++)
          if (mem_byteenable[b]) tb_mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= tb_mem[mem_address];
      end
    end
  end

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (m0_readdatavalid) m0_rdv_cnt++;
    if (m1_readdatavalid) m1_rdv_cnt++;
    if (mem_chipselect)   cs_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_valid = 1'b0; m0_write = 1'b0; m0_lock = 1'b0; m0_address = 14'd0;
    m0_byteenable = 8'hFF; m0_writedata = 64'd0;
    m1_valid = 1'b0; m1_write = 1'b0; m1_lock = 1'b0; m1_address = 14'd0;
    m1_byteenable = 8'hFF; m1_writedata = 64'd0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic v0, v1, l0, l1;
    logic r0, r1, cs;
  } vec_t;

  vec_t vt [15];
  int   acc0;
  logic pre_rdy, granted1;

  initial begin
    // v0 v1 l0 l1 | ready0 ready1 chipselect after the edge
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8960; i++) tb_mem[i] = {32'h1111_2222, 32'(i)};
    mem_readdata = 64'd0;

    // Reset state
    reset_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_ready0", {63'd0, m0_ready}, 64'd0);
    check("rst_ready1", {63'd0, m1_ready}, 64'd0);
    check("rst_clken", {63'd0, mem_clken}, 64'd0);
    check("rst_cs", {63'd0, mem_chipselect}, 64'd0);
    check("rst_err", {63'd0, addr_err}, 64'd0);
    check("rst_rdv", {62'd0, m0_readdatavalid, m1_readdatavalid}, 64'd0);
    check("rst_rdata0", m0_readdata, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("clken_on", {63'd0, mem_clken}, 64'd1);

    // Arbitration table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      m0_valid = vt[i].v0; m1_valid = vt[i].v1;
      m0_lock  = vt[i].l0; m1_lock  = vt[i].l1;
      tick();
      check($sformatf("tbl%0d_rdy0", i), {63'd0, m0_ready}, {63'd0, vt[i].r0});
      check($sformatf("tbl%0d_rdy1", i), {63'd0, m1_ready}, {63'd0, vt[i].r1});
      check($sformatf("tbl%0d_cs", i), {63'd0, mem_chipselect}, {63'd0, vt[i].cs});
    end

    // Single master write then read of address 5
    do_reset();
    m1_rdv_cnt = 0;
    m0_valid = 1'b1; m0_write = 1'b1; m0_address = 14'd5; m0_writedata = DATA_A;
    tick();
    check("a_grant0", {63'd0, m0_ready}, 64'd1);
    tick();
    check("a_wr_cs", {62'd0, mem_chipselect, mem_write}, 64'd3);
    check("a_wr_addr", {50'd0, mem_address}, 64'd5);
    check("a_wr_data", mem_writedata, DATA_A);
    m0_write = 1'b0;
    tick();
    check("a_rd_cs", {62'd0, mem_chipselect, mem_write}, 64'd2);
    m0_valid = 1'b0;
    tick();
    check("a_rdv_early", {63'd0, m0_readdatavalid}, 64'd0);
    tick();
    check("a_rdv", {63'd0, m0_readdatavalid}, 64'd1);
    check("a_rdata", m0_readdata, DATA_A);
    tick();
    check("a_rdv_once", {63'd0, m0_readdatavalid}, 64'd0);
    check("a_m1_rdv_none", 64'(m1_rdv_cnt), 64'd0);

    // Locked burst on m0 while m1 waits
    do_reset();
    m0_valid = 1'b1; m0_lock = 1'b1; m0_address = 14'd7;
    m1_valid = 1'b1; m1_address = 14'd5;
    acc0 = 0; granted1 = 1'b0;
    for (int c = 0; c < 40 && !granted1; c++) begin
      pre_rdy = m0_ready;
      tick();
      if (pre_rdy) acc0++;
      if (m1_ready) granted1 = 1'b1;
    end
    check("b_granted1", {63'd0, granted1}, 64'd1);
    check("b_m0_accepts", 64'(acc0), 64'd16);
    m1_rdv_cnt = 0;
    tick();
    m1_valid = 1'b0;
    tick();
    tick();
    check("b_m1_rdv", {63'd0, m1_readdatavalid}, 64'd1);
    check("b_m1_rdata", m1_readdata, DATA_A);
    m0_valid = 1'b0; m0_lock = 1'b0;
    tick(); tick(); tick();
    check("b_m1_rdv_count", 64'(m1_rdv_cnt), 64'd1);
    check("b_m0_rdata", m0_readdata, {32'h1111_2222, 32'd7});

    // m0 read then immediate switch to m1: returns steered by tag
    do_reset();
    m0_valid = 1'b1; m0_address = 14'd5;
    m1_valid = 1'b1; m1_address = 14'd6;
    tick();
    check("c_grant0", {63'd0, m0_ready}, 64'd1);
    tick();
    check("c_grant1", {63'd0, m1_ready}, 64'd1);
    m0_valid = 1'b0;
    tick();
    m1_valid = 1'b0;
    tick();
    check("c_rdv_e4", {62'd0, m0_readdatavalid, m1_readdatavalid}, 64'd2);
    check("c_m0_rdata", m0_readdata, DATA_A);
    tick();
    check("c_rdv_e5", {62'd0, m0_readdatavalid, m1_readdatavalid}, 64'd1);
    check("c_m1_rdata", m1_readdata, {32'h1111_2222, 32'd6});

    // Out-of-range write and read from m1
    cs_cnt = 0;
    m1_valid = 1'b1; m1_write = 1'b1; m1_address = 14'd8960;
    tick();
    tick();
    check("d_err_set", {63'd0, addr_err}, 64'd1);
    m1_write = 1'b0; m1_address = 14'd9000;
    tick();
    m1_valid = 1'b0;
    tick();
    tick();
    check("d_oob_rdv", {63'd0, m1_readdatavalid}, 64'd1);
    check("d_oob_rdata", m1_readdata, 64'd0);
    check("d_no_cs", 64'(cs_cnt), 64'd0);
    err_clr = 1'b1;
    tick();
    check("d_err_clr", {63'd0, addr_err}, 64'd0);
    m1_valid = 1'b1;
    tick();
    tick();
    check("d_set_wins", {63'd0, addr_err}, 64'd1);
    m1_valid = 1'b0; err_clr = 1'b0;
    tick(); tick(); tick();

    // Reset asserted one cycle after a read accept
    do_reset();
    m0_valid = 1'b1; m0_address = 14'd5;
    tick();
    tick();
    m0_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("e_ready0", {63'd0, m0_ready}, 64'd0);
    check("e_clken", {63'd0, mem_clken}, 64'd0);
    check("e_addr", {50'd0, mem_address}, 64'd0);
    tick();
    m0_rdv_cnt = 0;
    m1_rdv_cnt = 0;
    reset_n = 1'b1;
    tick(); tick(); tick(); tick();
    check("e_no_stray_rdv", 64'(m0_rdv_cnt + m1_rdv_cnt), 64'd0);
    m0_valid = 1'b1; m1_valid = 1'b1;
    tick();
    check("e_restart_prio", {62'd0, m0_ready, m1_ready}, 64'd2);
    idle_inputs();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
